// File: rtl/mqcr_scan_ctrl.sv
// Scan controller: reads a window of the correlation matrix in raster order,
// scales and saturates each word, and streams it out through a 2-entry FIFO.
module mqcr_scan_ctrl #(
    parameter int NUM_CAR_CHANNELS       = 35,
    parameter int F_IN_H                 = 13,
    parameter int F_IN_W                 = 29,
    parameter int START_ROW              = 6,
    parameter int FEATURE_MAP_RESOLUTION = 16,
    parameter int FEATURE_MAP_ADDRWIDE   = 12,
    parameter int SHIFT                  = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         start_i,
    input  logic                                         abort_i,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         rd_en_o,
    output logic [$clog2(NUM_CAR_CHANNELS)-1:0]          rd_row_o,
    output logic [$clog2(NUM_CAR_CHANNELS)-1:0]          rd_col_o,
    input  logic signed [2*FEATURE_MAP_RESOLUTION-1:0]   rd_data_i,
    output logic                                         out_valid_o,
    output logic signed [FEATURE_MAP_RESOLUTION-1:0]     out_data_o,
    output logic [FEATURE_MAP_ADDRWIDE-1:0]              out_addr_o,
    output logic                                         out_last_o,
    input  logic                                         out_ready_i
);

    localparam int RES = FEATURE_MAP_RESOLUTION;
    localparam int AW  = FEATURE_MAP_ADDRWIDE;
    localparam int DW  = 2 * RES;
    localparam int RW  = $clog2(NUM_CAR_CHANNELS);

    localparam logic [AW-1:0]  LAST_ADDR = AW'(F_IN_H * F_IN_W - 1);
    localparam logic [RW-1:0]  ROW_BASE  = RW'(START_ROW);
    localparam logic [RW-1:0]  LAST_COL  = RW'(F_IN_W - 1);
    localparam logic [RES-1:0] SAT_MIN   = {1'b1, {(RES-1){1'b0}}};
    localparam logic [RES-1:0] SAT_MAX   = ~SAT_MIN;

    if (START_ROW + F_IN_H > NUM_CAR_CHANNELS) begin : g_bad_rows
        $error("mqcr_scan_ctrl: START_ROW+F_IN_H exceeds NUM_CAR_CHANNELS");
    end
    if (F_IN_W > NUM_CAR_CHANNELS) begin : g_bad_cols
        $error("mqcr_scan_ctrl: F_IN_W exceeds NUM_CAR_CHANNELS");
    end
    if (longint'(F_IN_H) * longint'(F_IN_W) > (longint'(1) << AW)) begin : g_bad_aw
        $error("mqcr_scan_ctrl: F_IN_H*F_IN_W does not fit in the address width");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   r_q, c_q;
    logic [AW-1:0]   addr_q;
    logic            inflight_q;
    logic [AW-1:0]   infl_addr_q;
    logic            infl_last_q;

    logic [RES-1:0]  fifo_data_q [2];
    logic [AW-1:0]   fifo_addr_q [2];
    logic            fifo_last_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      count_q;

    logic            active, kill, push, pop, issue, scan_end;
    logic [2:0]      occ;
    logic signed [DW-1:0] shifted;
    logic            overflow;
    logic [RES-1:0]  sat_data;

    // An abort only matters while a scan is live; it outranks any handshake.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        active   = (state_q == RUN) || (state_q == DRAIN);
        kill     = abort_i && active;
        push     = inflight_q && !kill;
        pop      = (count_q != 2'd0) && out_ready_i && !kill;
        occ      = {1'b0, count_q} + {2'b00, inflight_q};
        issue    = (state_q == RUN) && !abort_i && ((occ - {2'b00, pop}) < 3'd2);
        scan_end = issue && (addr_q == LAST_ADDR);
    end

    always_comb begin
        shifted  = rd_data_i >>> SHIFT;
        overflow = !((&shifted[DW-1:RES-1]) || !(|shifted[DW-1:RES-1]));
        sat_data = shifted[RES-1:0];
        if (overflow) begin
            sat_data = shifted[DW-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        busy_o      = active;
        done_o      = (state_q == DONE);
        rd_en_o     = issue;
        rd_row_o    = '0;
        rd_col_o    = '0;
        if (state_q == RUN) begin
            rd_row_o = ROW_BASE + r_q;
            rd_col_o = c_q;
        end
        out_valid_o = (count_q != 2'd0);
        out_data_o  = fifo_data_q[rd_ptr_q];
        out_addr_o  = fifo_addr_q[rd_ptr_q];
        out_last_o  = out_valid_o && fifo_last_q[rd_ptr_q];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (abort_i) state_d = IDLE;
                     else if (scan_end) state_d = DRAIN;
            DRAIN:   if (abort_i) state_d = IDLE;
                     else if (pop && out_last_o) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Raster counters restart from (0,0) whenever the block is idle or aborted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else if (state_q == IDLE || kill) begin
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else if (issue) begin
            addr_q <= addr_q + AW'(1);
            if (c_q == LAST_COL) begin
                c_q <= '0;
                r_q <= r_q + RW'(1);
            end else begin
                c_q <= c_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            infl_last_q <= 1'b0;
        end else begin
            inflight_q  <= issue && !kill;
            infl_addr_q <= addr_q;
            infl_last_q <= (addr_q == LAST_ADDR);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (kill) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the FIFO storage is reset because its head entry drives the output bus directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= sat_data;
            fifo_addr_q[wr_ptr_q] <= infl_addr_q;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
        end
    end

endmodule

// File: tb/tb_mqcr_scan_ctrl.sv
// Self-checking bench for mqcr_scan_ctrl: matrix memory model, stream monitor
// with a reference of expected beats, and directed multi-cycle sequences.
module tb_mqcr_scan_ctrl;

    localparam int N     = 35;
    localparam int H     = 13;
    localparam int W     = 29;
    localparam int SR    = 6;
    localparam int SH    = 4;
    localparam int BEATS = H * W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, rd_en, out_valid, out_last;
    logic [5:0]  rd_row, rd_col;
    logic [31:0] rd_data = '0;
    logic [15:0] out_data;
    logic [11:0] out_addr;

    int mat [N][N];

    int total = 0;
    int bad   = 0;
    int reads = 0;
    int beats = 0;
    int dones = 0;

    logic [15:0] got [BEATS];
    logic [15:0] hold_data;
    logic [11:0] hold_addr;
    logic        hold_last;
    bit          stalled = 0;

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
    } vec_t;
    vec_t vecs [8];

    mqcr_scan_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .rd_en_o     (rd_en),
        .rd_row_o    (rd_row),
        .rd_col_o    (rd_col),
        .rd_data_i   (rd_data),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_addr_o  (out_addr),
        .out_last_o  (out_last),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    // Matrix memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mat[rd_row][rd_col];
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beat k: matrix word at window position k, scaled and clamped.
    function automatic logic [15:0] exp_data(input int k);
        longint v;
        v = longint'(mat[SR + k / W][k % W]) >>> SH;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    always @(negedge clk) begin
        bit hs;
        int occ;
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hold_data);
                check("stall_addr", out_addr, hold_addr);
                check("stall_last", out_last, hold_last);
            end
            hs = out_valid && out_ready && !abort;
            if (rd_en) begin
                check("rd_row", rd_row, SR + reads / W);
                check("rd_col", rd_col, reads % W);
                occ = reads + 1 - beats - int'(hs);
                check("outstanding_le2", occ <= 2, 1);
                reads++;
            end
            if (hs) begin
                if (beats < BEATS) begin
                    check("beat_addr", out_addr, beats);
                    check("beat_data", out_data, exp_data(beats));
                    check("beat_last", out_last, beats == BEATS - 1);
                    got[beats] = out_data;
                end else begin
                    check("extra_beat", beats, BEATS - 1);
                end
                beats++;
            end
            if (done) begin
                dones++;
                check("done_after_last", beats, BEATS);
            end
            stalled   = out_valid && !out_ready && !abort;
            hold_data = out_data;
            hold_addr = out_addr;
            hold_last = out_last;
        end
    end

    task automatic clear_counts();
        reads = 0;
        beats = 0;
        dones = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"},  out_last, 0);
        check({tag, "_row"},   rd_row, 0);
        check({tag, "_col"},   rd_col, 0);
        check({tag, "_data"},  out_data, 0);
        check({tag, "_addr"},  out_addr, 0);
    endtask

    task automatic run_scan(input int ready_pct, input int start_again_at, input int budget);
        bit seen;
        clear_counts();
        out_ready = 1'b1;
        pulse_start();
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            start     = (i == start_again_at);
            @(posedge clk); #1;
            if (dones > 0) seen = 1;
        end
        start = 1'b0;
        check("scan_finished", seen, 1);
        check("beat_count", beats, BEATS);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", dones, 1);
        check("idle_after_scan", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{32'h0001_2340, 16'h1234};
        vecs[1] = '{32'h7FFF_FFFF, 16'h7FFF};
        vecs[2] = '{32'h8000_0000, 16'h8000};
        vecs[3] = '{32'hFFFF_FFE0, 16'hFFFE};
        vecs[4] = '{32'h0007_FFF0, 16'h7FFF};
        vecs[5] = '{32'h0008_0000, 16'h7FFF};
        vecs[6] = '{32'hFFF7_FFF0, 16'h8000};
        vecs[7] = '{32'hFFFF_FFFF, 16'hFFFF};

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = (i * 64 + j) << 4;

        // Reset state, including a start request while held in reset.
        out_ready = 1'b1;
        #3 check_all_zero("reset");
        start = 1'b1;
        #10 check_all_zero("reset_start");
        start = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", busy, 0);

        // Full scan, latency and back-to-back throughput.
        clear_counts();
        out_ready = 1'b1;
        pulse_start();
        check("c1_valid", out_valid, 0);
        check("c1_busy", busy, 1);
        check("c1_rd_en", rd_en, 1);
        check("c1_row", rd_row, SR);
        @(posedge clk); #1;
        check("c2_valid", out_valid, 0);
        @(posedge clk); #1;
        check("c3_valid", out_valid, 1);
        check("c3_addr", out_addr, 0);
        cyc = 3;
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_cycle", cyc, 380);
        check("full_beats", beats, BEATS);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("full_dones", dones, 1);

        // Saturation vectors placed at the head of the window.
        for (int i = 0; i < 8; i++) mat[SR][i] = int'(vecs[i].din);
        run_scan(100, -1, 1000);
        for (int i = 0; i < 8; i++) check($sformatf("sat_vec%0d", i), got[i], vecs[i].dout);

        // Random data under 30% ready backpressure.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = int'($urandom);
        run_scan(30, -1, 5000);

        // Extra start pulse in mid-scan must be ignored.
        run_scan(70, 50, 3000);

        // Abort while beat 100 is stalled.
        clear_counts();
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 1000 && beats < 100; i++) begin
            @(posedge clk); #1;
        end
        check("abort_reached_100", beats, 100);
        out_ready = 1'b0;
        abort     = 1'b1;
        check("abort_valid_before", out_valid, 1);
        check("abort_addr_before", out_addr, 100);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid_after", out_valid, 0);
        check("abort_busy_after", busy, 0);
        check("abort_done_after", done, 0);
        check("abort_rd_en_after", rd_en, 0);
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", dones, 0);
        check("abort_no_beats", beats, 100);
        run_scan(100, -1, 1000);

        // Reset while draining.
        clear_counts();
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 1000 && reads < BEATS; i++) begin
            @(posedge clk); #1;
        end
        check("drain_busy", busy, 1);
        check("drain_rd_en", rd_en, 0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_no_done", dones, 0);
        check("reset_idle", busy, 0);
        run_scan(100, -1, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
